scan_select_gen: RTL and testbench
==================================

// Module: scan_select_gen
// PURPOSE
//   Generates the 3-bit one-of-eight select index S feeding the downstream 3-to-8 decoder.
//   Steps S through the enabled outputs in one of two ways:
//     - automatically, at a prescaled rate (AUTO);
//     - one position per request/acknowledge handshake (STEP).
//   Disabled indices (mask bit = 0) are skipped; direction is selectable.
//   Sits directly upstream of the decoder; S connects straight to the decoder's select input.
// PARAMETERS
//   DIV_W   16   width of prescaler divide value div
// PORTS
//   clk       in   1      system clock, rising-edge
//   rst       in   1      asynchronous, active-high reset
//   en        in   1      1 = block active; 0 = freeze S, clear prescaler
//   mode      in   1      0 = AUTO (advance on prescaler tick), 1 = STEP (advance on handshake)
//   dir       in   1      0 = up (increment index), 1 = down (decrement index)
//   div       in   DIV_W  tick period minus 1 (0 = tick every cycle)
//   mask      in   8      mask[i]=1 -> index i enabled
//   load      in   1      one-cycle pulse: S <= load_idx
//   load_idx  in   3      index to load
//   step_req  in   1      STEP-mode request (level; acted on at rising edge)
//   step_ack  out  1      one-cycle pulse, same edge that S advances for a step
//   S         out  3      select index to decoder (registered)
//   S_valid   out  1      registered: en & mask[S]
//   wrap      out  1      one-cycle pulse when an advance crosses 7->0 (up) or 0->7 (down)
//   tick      out  1      one-cycle prescaler tick (AUTO timing visibility)
// BEHAVIOUR
//   Reset: S=0, S_valid=0, step_ack=0, wrap=0, tick=0, prescaler=0, req edge reg=0, state=IDLE.
//   State machine:
//     IDLE -> RUN: en=1 and mask!=0.
//     RUN -> IDLE: en=0 or mask==0. S holds its value in IDLE.
//   Prescaler (RUN, mode=0 only):
//     - Counts 0..div; tick=1 on the cycle count==div, then count returns to 0.
//     - Cleared in IDLE, in mode=1, and on load.
//     - A change to div takes effect at the next count compare.
//   Advance event:
//     - AUTO: tick. STEP: rising edge of step_req (registered edge detect).
//     - S <= next enabled index strictly after S in direction dir, modulo 8.
//     - If S is the only enabled index: S unchanged; wrap=1.
//     - Latency: S updates on the clock edge after the tick/edge cycle.
//     - step_ack pulses with the S update; at most one step per step_req high period.
//   wrap: set on the advance edge iff the search crossed the 7/0 boundary in the travel direction.
//   load: priority over advance in the same cycle.
//     - S <= load_idx even if masked; the advance is dropped.
//     - A step dropped this way is not acknowledged.
//   S_valid:
//     - Registered from next-state: en & mask[next S].
//     - A mask change clearing the current bit drops S_valid one cycle later; S moves only on the next advance.
//   Mode change mid-run: takes effect the next cycle; a pending step_req edge is discarded when mode=0.
//   en deassert: no further advances; step_ack/wrap/tick forced 0; S_valid=0 the next cycle.
//   Reset mid-operation: all outputs return to reset values immediately (async); no partial advance survives.
// STRUCTURE
//   Package scan_pkg:
//     - constants IDX_W=3, NUM_SEL=8;
//     - typedef for state {IDLE, RUN};
//     - MODE_AUTO/MODE_STEP constants.
//   Sub-module scan_prescaler (DIV_W, clk, rst, clr, en, div -> tick).
//   Top holds: FSM, step edge detect, next-enabled-index priority search (rotate mask by S, find first), load mux.
// TESTING
//   1. Reset, en=1, mode=0, dir=0, div=0, mask=8'hFF -> S walks 0,1..7,0 every cycle; wrap with 7->0; S_valid=1.
//   2. mask=8'b1010_0101, dir=0, div=2 -> S=0,2,5,7,0; each value held 3 cycles; wrap on 7->0.
//   3. dir=1, mask=8'hFF, S=0 -> next S=7 with wrap=1, then 6 with wrap=0.
//   4. mode=1, mask=8'hFF, S=3:
//      - hold step_req high 10 cycles -> exactly one step_ack; S=4.
//      - drop and re-raise step_req -> S=5.
//   5. load=1, load_idx=6, mask[6]=0, coincident tick -> S=6, S_valid=0, no wrap/ack; next tick -> S=7.
//   6. Assert rst mid-run with S=5 -> S=0, S_valid=0 without a clock edge; mask=0 with en=1 -> stays IDLE, S frozen.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared constants and types for the scan select generator.
package scan_pkg;

  localparam int IDX_W   = 3;
  localparam int NUM_SEL = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic MODE_AUTO = 1'b0;
  localparam logic MODE_STEP = 1'b1;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/scan_prescaler.sv
// Programmable tick prescaler: counts 0..div_i and flags the terminal cycle.
// The compare is against the live div_i, so a new divide value is picked up
// at the next compare; ">=" keeps a shrinking div_i from overrunning the count.
module scan_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // Terminal-count compare and next count value.
  always_comb begin
    tick_o = en_i && (cnt_q >= div_i);
    cnt_d  = cnt_q;
    if (clr_i || !en_i) begin
      cnt_d = '0;
    end else if (tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/scan_select_gen.sv
// One-of-eight select index generator for the downstream 3-to-8 decoder.
// Steps the index through enabled positions either on prescaler ticks (AUTO)
// or once per rising edge of step_req_i (STEP), in the selected direction.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | disabled or nothing enabled; index frozen, prescaler cleared
//   RUN   | advancing on tick (AUTO) or step_req rising edge (STEP)
module scan_select_gen
  import scan_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             mode_i,
  input  logic             dir_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [7:0]       mask_i,
  input  logic             load_i,
  input  logic [2:0]       load_idx_i,
  input  logic             step_req_i,
  output logic             step_ack_o,
  output logic [2:0]       s_o,
  output logic             s_valid_o,
  output logic             wrap_o,
  output logic             tick_o
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] s_q, s_d;
  logic             s_valid_q, s_valid_d;
  logic             wrap_q, wrap_d;
  logic             ack_q, ack_d;
  logic             req_q;

  logic             presc_en;
  logic             tick;
  logic             step_edge;
  logic             run_en;
  logic             adv;

  logic             found;
  logic [IDX_W-1:0] nxt_idx;
  logic             nxt_wrap;
  logic [IDX_W-1:0] cand;

  assign run_en    = (state_q == RUN) && en_i;
  assign presc_en  = run_en && (mode_i == MODE_AUTO);
  assign step_edge = step_req_i && !req_q;

  scan_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (load_i),
    .en_i   (presc_en),
    .div_i  (div_i),
    .tick_o (tick)
  );

  // First enabled index strictly after s_q in the travel direction; offset 8
  // lands back on s_q itself, which is how the single-enabled case wraps.
  always_comb begin
    found    = 1'b0;
    nxt_idx  = s_q;
    nxt_wrap = 1'b0;
    cand     = s_q;
    for (int k = 1; k <= NUM_SEL; k++) begin
      if (!found) begin
        cand = (dir_i == DIR_DOWN) ? (s_q - k[IDX_W-1:0]) : (s_q + k[IDX_W-1:0]);
        if (mask_i[cand]) begin
          found    = 1'b1;
          nxt_idx  = cand;
          nxt_wrap = (dir_i == DIR_DOWN) ? (k > int'(s_q))
                                         : ((int'(s_q) + k) >= NUM_SEL);
        end
      end
    end
  end

  assign adv = run_en && found &&
               ((mode_i == MODE_AUTO) ? tick : step_edge);

  // Next state, load/advance mux and registered output values.
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    wrap_d    = 1'b0;
    ack_d     = 1'b0;
    s_valid_d = 1'b0;

    case (state_q)
      IDLE: if (en_i && (mask_i != 8'h00)) state_d = RUN;
      RUN:  if (!en_i || (mask_i == 8'h00)) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (en_i && load_i) begin
      s_d = load_idx_i;
    end else if (adv) begin
      s_d    = nxt_idx;
      wrap_d = nxt_wrap;
      ack_d  = (mode_i == MODE_STEP);
    end

    s_valid_d = en_i && mask_i[s_d];
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      s_q       <= '0;
      s_valid_q <= 1'b0;
      wrap_q    <= 1'b0;
      ack_q     <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      s_valid_q <= s_valid_d;
      wrap_q    <= wrap_d;
      ack_q     <= ack_d;
      req_q     <= step_req_i;
    end
  end

  assign s_o        = s_q;
  assign s_valid_o  = s_valid_q;
  assign wrap_o     = wrap_q;
  assign step_ack_o = ack_q;
  assign tick_o     = tick;

endmodule

// File: tb/tb_scan_select_gen.sv
module tb_scan_select_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, mode, dir, load, step_req;
  logic [15:0] div;
  logic [7:0]  mask;
  logic [2:0]  load_idx;
  logic        step_ack, s_valid, wrap, tick;
  logic [2:0]  s;

  int errors = 0;
  int checks = 0;

  scan_select_gen #(.DIV_W(16)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .mode_i     (mode),
    .dir_i      (dir),
    .div_i      (div),
    .mask_i     (mask),
    .load_i     (load),
    .load_idx_i (load_idx),
    .step_req_i (step_req),
    .step_ack_o (step_ack),
    .s_o        (s),
    .s_valid_o  (s_valid),
    .wrap_o     (wrap),
    .tick_o     (tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst_before;
    logic        en, mode, dir;
    logic [15:0] div;
    logic [7:0]  mask;
    int          s, valid, wrap, ack, tick;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic void add(bit r, logic e, logic m, logic d, logic [15:0] dv,
                              logic [7:0] mk, int es, int ev, int ew, int ea, int et);
    vec_t x;
    x.rst_before = r; x.en = e; x.mode = m; x.dir = d; x.div = dv; x.mask = mk;
    x.s = es; x.valid = ev; x.wrap = ew; x.ack = ea; x.tick = et;
    vecs.push_back(x);
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    en = 0; mode = 0; dir = 0; div = 0; mask = 0; load = 0; load_idx = 0; step_req = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Reference model state (spec-level, plain arithmetic).
  int m_s, m_cnt;
  bit m_run, m_req, m_ack, m_wrap, m_valid;

  function automatic bit m_tick();
    return m_run && en && (mode == 1'b0) && (m_cnt == int'(div));
  endfunction

  task automatic model_reset();
    m_s = 0; m_cnt = 0; m_run = 0; m_req = 0; m_ack = 0; m_wrap = 0; m_valid = 0;
  endtask

  task automatic model_edge();
    bit t, rose, want, hit, crossed;
    int idx, pos;
    t = m_tick();
    rose = step_req && !m_req;
    want = m_run && en && ((mode == 1'b0) ? t : rose);
    hit = 0; idx = m_s; crossed = 0;
    if (want && mask != 8'h00) begin
      for (int k = 1; k <= 8; k++) begin
        if (!hit) begin
          pos = dir ? (m_s - k) : (m_s + k);
          if (mask[((pos % 8) + 8) % 8]) begin
            hit = 1; idx = ((pos % 8) + 8) % 8; crossed = (pos < 0) || (pos > 7);
          end
        end
      end
    end
    m_ack = 0; m_wrap = 0;
    if (en && load) m_s = int'(load_idx);
    else if (hit) begin
      m_s = idx; m_wrap = crossed; m_ack = (mode == 1'b1);
    end
    m_valid = en && mask[m_s];
    if (!(m_run && en && mode == 1'b0) || load) m_cnt = 0;
    else if (t) m_cnt = 0;
    else m_cnt = m_cnt + 1;
    m_req = step_req;
    m_run = en && (mask != 8'h00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int seq2[5];
    int acks, n;
    bit got;
    rst = 1'b1;
    en = 0; mode = 0; dir = 0; div = 0; mask = 0; load = 0; load_idx = 0; step_req = 0;

    // Test 1: full mask, div=0, up.
    add(1, 1, 0, 0, 16'd0, 8'hFF, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 16'd0, 8'hFF, 0, 1, 0, 0, 1);
    for (int c = 2; c <= 8; c++) add(0, 1, 0, 0, 16'd0, 8'hFF, c - 1, 1, 0, 0, 1);
    add(0, 1, 0, 0, 16'd0, 8'hFF, 0, 1, 1, 0, 1);
    add(0, 1, 0, 0, 16'd0, 8'hFF, 1, 1, 0, 0, 1);
    // Test 2: sparse mask, div=2.
    seq2[0] = 0; seq2[1] = 2; seq2[2] = 5; seq2[3] = 7; seq2[4] = 0;
    add(1, 1, 0, 0, 16'd2, 8'hA5, 0, 0, 0, 0, 0);
    for (int c = 1; c <= 13; c++)
      add(0, 1, 0, 0, 16'd2, 8'hA5, seq2[(c - 1) / 3], 1, (c == 13) ? 1 : 0, 0,
          ((c - 1) % 3 == 2) ? 1 : 0);
    // Test 3: down direction from 0.
    add(1, 1, 0, 1, 16'd0, 8'hFF, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 16'd0, 8'hFF, 0, 1, 0, 0, 1);
    add(0, 1, 0, 1, 16'd0, 8'hFF, 7, 1, 1, 0, 1);
    add(0, 1, 0, 1, 16'd0, 8'hFF, 6, 1, 0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst_before) do_reset();
      en = vecs[i].en; mode = vecs[i].mode; dir = vecs[i].dir;
      div = vecs[i].div; mask = vecs[i].mask; load = 0; step_req = 0;
      @(negedge clk);
      chk($sformatf("v%0d_s", i), int'(s), vecs[i].s);
      chk($sformatf("v%0d_valid", i), int'(s_valid), vecs[i].valid);
      chk($sformatf("v%0d_wrap", i), int'(wrap), vecs[i].wrap);
      chk($sformatf("v%0d_ack", i), int'(step_ack), vecs[i].ack);
      chk($sformatf("v%0d_tick", i), int'(tick), vecs[i].tick);
      @(posedge clk); #1;
    end

    // Test 4: STEP mode, one ack per request high period.
    do_reset();
    en = 1; mode = 1; mask = 8'hFF;
    @(posedge clk); #1;
    load = 1; load_idx = 3;
    @(posedge clk); #1;
    load = 0;
    chk("t4_load_s", int'(s), 3);
    step_req = 1; acks = 0;
    repeat (10) begin
      @(negedge clk);
      if (step_ack) acks++;
      @(posedge clk); #1;
    end
    chk("t4_ack_count", acks, 1);
    chk("t4_s_after_hold", int'(s), 4);
    step_req = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    step_req = 1; got = 0;
    for (int i = 0; i < 5 && !got; i++) begin
      @(negedge clk);
      if (step_ack) got = 1;
      else begin @(posedge clk); #1; end
    end
    chk("t4_second_ack", int'(got), 1);
    chk("t4_second_s", int'(s), 5);
    @(posedge clk); #1;
    step_req = 0;

    // Test 5: load coincident with tick, masked target.
    do_reset();
    en = 1; mode = 0; dir = 0; div = 2; mask = 8'hBF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    load = 1; load_idx = 6;
    @(negedge clk);
    chk("t5_tick_coincident", int'(tick), 1);
    @(posedge clk); #1;
    load = 0;
    chk("t5_s_loaded", int'(s), 6);
    chk("t5_valid", int'(s_valid), 0);
    chk("t5_wrap", int'(wrap), 0);
    chk("t5_ack", int'(step_ack), 0);
    n = 0;
    while (s == 3'd6 && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t5_hold_cycles", n, 3);
    chk("t5_s_next", int'(s), 7);

    // Test 6: async reset mid-run, then mask=0 keeps idle.
    do_reset();
    en = 1; mode = 0; dir = 0; div = 0; mask = 8'hFF;
    n = 0;
    while (s != 3'd5 && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t6_reach5", int'(s), 5);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_s", int'(s), 0);
    chk("t6_async_valid", int'(s_valid), 0);
    chk("t6_async_tick", int'(tick), 0);
    @(posedge clk); #1;
    rst = 1'b0; mask = 8'h00; en = 1;
    repeat (4) begin
      @(negedge clk);
      chk("t6_idle_s", int'(s), 0);
      chk("t6_idle_tick", int'(tick), 0);
      chk("t6_idle_valid", int'(s_valid), 0);
      @(posedge clk); #1;
    end

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    mask = 8'hFF;
    for (int seg = 0; seg < 40; seg++) begin
      for (int c = 0; c < 50; c++) begin
        if (c == 0) begin
          en = 0;
          div = 16'($urandom_range(0, 3));
        end else begin
          en = ($urandom_range(0, 15) != 0);
        end
        if ($urandom_range(0, 31) == 0) mode = ~mode;
        dir = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 15) == 0)
          mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
        load = ($urandom_range(0, 9) == 0);
        load_idx = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 2) == 0) step_req = ~step_req;
        @(negedge clk);
        chk("rnd_s", int'(s), m_s);
        chk("rnd_valid", int'(s_valid), int'(m_valid));
        chk("rnd_wrap", int'(wrap), int'(m_wrap));
        chk("rnd_ack", int'(step_ack), int'(m_ack));
        chk("rnd_tick", int'(tick), int'(m_tick()));
        @(posedge clk);
        model_edge();
        #1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
